cpu_retire_trace_tx: RTL and testbench

- CPU-side transmitter that drives the retire/GPR-writeback trace pad interface.
- Testbench monitors sample this interface to build GPR.log.
- Collects internal retire events and GPR writebacks, including load writebacks that arrive after retire, and reorders them into an in-order record stream.
- Emits each record as a single aligned cycle in which retire, PC and GPR writeback are all valid together.
- Sits between the core retire/writeback logic and the BIU trace pads of the AHB CPU subsystem.

---
 rtl/cpu_retire_trace_tx_if.sv | 25 ++
 rtl/cpu_retire_trace_tx.sv | 139 +++++++++++++
 tb/tb_cpu_retire_trace_tx.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_retire_trace_tx_if.sv
// Retire/GPR-writeback trace pad bundle between the CPU trace transmitter
// and the BIU pads; the transmitter drives it, pad-side monitors sample it.
interface cpu_retire_trace_tx_if;
    logic        biu_pad_retire;
    logic [31:0] biu_pad_retire_pc;
    logic        biu_pad_wb_gpr_en;
    logic [4:0]  biu_pad_wb_gpr_index;
    logic [31:0] biu_pad_wb_gpr_data;

    modport master (
        output biu_pad_retire,
        output biu_pad_retire_pc,
        output biu_pad_wb_gpr_en,
        output biu_pad_wb_gpr_index,
        output biu_pad_wb_gpr_data
    );

    modport slave (
        input biu_pad_retire,
        input biu_pad_retire_pc,
        input biu_pad_wb_gpr_en,
        input biu_pad_wb_gpr_index,
        input biu_pad_wb_gpr_data
    );
endinterface

// File: rtl/cpu_retire_trace_tx.sv
// Retire trace transmitter: buffers retire events, merges late load writebacks
// and emits one aligned retire/PC/GPR record per cycle in strict retire order.
module cpu_retire_trace_tx #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                          clk,
    input  logic                          rst_b,
    input  logic                          ret_vld,
    input  logic [31:0]                   ret_pc,
    input  logic                          ret_wb_late,
    input  logic                          wb_gpr_en,
    input  logic [4:0]                    wb_gpr_index,
    input  logic [31:0]                   wb_gpr_data,
    input  logic                          lwb_vld,
    input  logic [4:0]                    lwb_index,
    input  logic [31:0]                   lwb_data,
    cpu_retire_trace_tx_if.master         pad,
    output logic                          trace_busy,
    output logic                          trace_ovf,
    output logic                          trace_lwb_err
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [31:0]      pc_r   [DEPTH];
    logic [4:0]       idx_r  [DEPTH];
    logic [31:0]      data_r [DEPTH];
    logic [DEPTH-1:0] en_r;
    logic [DEPTH-1:0] pend_r;

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_nxt_s;

    logic             pop_s;
    logic             push_s;
    logic             lwb_hit_s;
    logic [PTR_W-1:0] lwb_ptr_s;
    logic [PTR_W-1:0] cand_s;
    logic             take_s;

    // Pop/push decisions; a full buffer still accepts a push when the head leaves.
    always_comb begin
        pop_s       = (count_r != {(PTR_W+1){1'b0}}) && !pend_r[rd_ptr_r];
        push_s      = ret_vld && ((count_r != FULL_CNT) || pop_s);
        count_nxt_s = count_r + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, pop_s};
    end

    // Late-writeback pointer: oldest occupied entry still waiting for its load data.
    always_comb begin
        lwb_hit_s = 1'b0;
        lwb_ptr_s = rd_ptr_r;
        cand_s    = rd_ptr_r;
        take_s    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cand_s    = rd_ptr_r + PTR_W'(i);
            take_s    = !lwb_hit_s && ((PTR_W+1)'(i) < count_r) && pend_r[cand_s];
            lwb_ptr_s = take_s ? cand_s : lwb_ptr_s;
            lwb_hit_s = lwb_hit_s | take_s;
        end
    end

    // Record buffer storage and pointers; x0 writes keep data but never assert en.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_r[i]   <= 32'h0000_0000;
                idx_r[i]  <= 5'd0;
                data_r[i] <= 32'h0000_0000;
            end
            en_r     <= {DEPTH{1'b0}};
            pend_r   <= {DEPTH{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (lwb_vld && lwb_hit_s) begin
                pend_r[lwb_ptr_s] <= 1'b0;
                en_r[lwb_ptr_s]   <= (lwb_index != 5'd0);
                idx_r[lwb_ptr_s]  <= lwb_index;
                data_r[lwb_ptr_s] <= lwb_data;
            end
            if (push_s) begin
                pc_r[wr_ptr_r] <= ret_pc;
                if (ret_wb_late) begin
                    pend_r[wr_ptr_r] <= 1'b1;
                    en_r[wr_ptr_r]   <= 1'b0;
                end else begin
                    pend_r[wr_ptr_r] <= 1'b0;
                    en_r[wr_ptr_r]   <= wb_gpr_en && (wb_gpr_index != 5'd0);
                    idx_r[wr_ptr_r]  <= wb_gpr_index;
                    data_r[wr_ptr_r] <= wb_gpr_data;
                end
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            count_r <= count_nxt_s;
        end
    end

    // Pad outputs: one-cycle record strobe; fields hold, write enable drops between records.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pad.biu_pad_retire       <= 1'b0;
            pad.biu_pad_retire_pc    <= 32'h0000_0000;
            pad.biu_pad_wb_gpr_en    <= 1'b0;
            pad.biu_pad_wb_gpr_index <= 5'd0;
            pad.biu_pad_wb_gpr_data  <= 32'h0000_0000;
        end else begin
            pad.biu_pad_retire <= pop_s;
            if (pop_s) begin
                pad.biu_pad_retire_pc    <= pc_r[rd_ptr_r];
                pad.biu_pad_wb_gpr_en    <= en_r[rd_ptr_r];
                pad.biu_pad_wb_gpr_index <= idx_r[rd_ptr_r];
                pad.biu_pad_wb_gpr_data  <= data_r[rd_ptr_r];
            end else begin
                pad.biu_pad_wb_gpr_en    <= 1'b0;
            end
        end
    end

    // Status flags; overflow and orphan late-writeback errors stick until reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            trace_busy    <= 1'b0;
            trace_ovf     <= 1'b0;
            trace_lwb_err <= 1'b0;
        end else begin
            trace_busy    <= (count_nxt_s != {(PTR_W+1){1'b0}});
            trace_ovf     <= trace_ovf | (ret_vld & ~push_s);
            trace_lwb_err <= trace_lwb_err | (lwb_vld & ~lwb_hit_s);
        end
    end

endmodule

// File: tb/tb_cpu_retire_trace_tx.sv
// Bench for cpu_retire_trace_tx: directed scenarios plus random traffic
// compared every cycle against a queue-based record model.
module tb_cpu_retire_trace_tx;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        ret_vld;
    logic [31:0] ret_pc;
    logic        ret_wb_late;
    logic        wb_gpr_en;
    logic [4:0]  wb_gpr_index;
    logic [31:0] wb_gpr_data;
    logic        lwb_vld;
    logic [4:0]  lwb_index;
    logic [31:0] lwb_data;
    logic        trace_busy;
    logic        trace_ovf;
    logic        trace_lwb_err;

    cpu_retire_trace_tx_if pad_if ();

    cpu_retire_trace_tx #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .ret_vld       (ret_vld),
        .ret_pc        (ret_pc),
        .ret_wb_late   (ret_wb_late),
        .wb_gpr_en     (wb_gpr_en),
        .wb_gpr_index  (wb_gpr_index),
        .wb_gpr_data   (wb_gpr_data),
        .lwb_vld       (lwb_vld),
        .lwb_index     (lwb_index),
        .lwb_data      (lwb_data),
        .pad           (pad_if),
        .trace_busy    (trace_busy),
        .trace_ovf     (trace_ovf),
        .trace_lwb_err (trace_lwb_err)
    );

    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    typedef struct {
        logic [31:0] pc;
        logic        en;
        logic [4:0]  idx;
        logic [31:0] data;
        logic        pend;
    } rec_t;

    rec_t        q[$];
    logic        exp_ret, exp_en, exp_ovf, exp_err;
    logic [31:0] exp_pc, exp_data;
    logic [4:0]  exp_idx;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_ret = 1'b0; exp_en = 1'b0; exp_ovf = 1'b0; exp_err = 1'b0;
        exp_pc = 32'h0; exp_data = 32'h0; exp_idx = 5'd0;
    endtask

    // One clock edge of the record model, from the inputs sampled at that edge.
    task automatic model_edge();
        bit   do_pop;
        int   k;
        rec_t r;
        do_pop = (q.size() != 0) && !q[0].pend;
        if (lwb_vld) begin
            k = -1;
            foreach (q[i]) if (k < 0 && q[i].pend) k = i;
            if (k >= 0) begin
                r = q[k];
                r.pend = 1'b0;
                r.en   = (lwb_index != 5'd0);
                r.idx  = lwb_index;
                r.data = lwb_data;
                q[k]   = r;
            end else begin
                exp_err = 1'b1;
            end
        end
        exp_ret = do_pop;
        if (do_pop) begin
            r = q.pop_front();
            exp_pc = r.pc; exp_en = r.en; exp_idx = r.idx; exp_data = r.data;
        end else begin
            exp_en = 1'b0;
        end
        if (ret_vld) begin
            if (q.size() < DEPTH) begin
                r.pc   = ret_pc;
                r.pend = ret_wb_late;
                r.en   = !ret_wb_late && wb_gpr_en && (wb_gpr_index != 5'd0);
                r.idx  = wb_gpr_index;
                r.data = wb_gpr_data;
                q.push_back(r);
            end else begin
                exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk_eq("retire", pad_if.biu_pad_retire, exp_ret);
        chk_eq("pc",     pad_if.biu_pad_retire_pc, exp_pc);
        chk_eq("wb_en",  pad_if.biu_pad_wb_gpr_en, exp_en);
        chk_eq("wb_idx", pad_if.biu_pad_wb_gpr_index, exp_idx);
        chk_eq("wb_data", pad_if.biu_pad_wb_gpr_data, exp_data);
        chk_eq("busy",   trace_busy, q.size() != 0);
        chk_eq("ovf",    trace_ovf, exp_ovf);
        chk_eq("lwb_err", trace_lwb_err, exp_err);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_b) model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input bit rv, input logic [31:0] pc, input bit late, input bit we,
                         input logic [4:0] wi, input logic [31:0] wd,
                         input bit lv, input logic [4:0] li, input logic [31:0] ld);
        ret_vld = rv; ret_pc = pc; ret_wb_late = late;
        wb_gpr_en = we; wb_gpr_index = wi; wb_gpr_data = wd;
        lwb_vld = lv; lwb_index = li; lwb_data = ld;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    int n_emit;

    initial begin
        idle();
        rst_b = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;

        // Single complete retire: record appears after two edges.
        drive(1'b1, 32'h0000_0100, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
        tick();
        chk_eq("t1_not_yet", pad_if.biu_pad_retire, 1'b0);
        idle();
        tick();
        chk_eq("t1_ret", pad_if.biu_pad_retire, 1'b1);
        chk_eq("t1_pc", pad_if.biu_pad_retire_pc, 32'h0000_0100);
        chk_eq("t1_en", pad_if.biu_pad_wb_gpr_en, 1'b1);
        chk_eq("t1_idx", pad_if.biu_pad_wb_gpr_index, 5'd5);
        chk_eq("t1_data", pad_if.biu_pad_wb_gpr_data, 32'hDEAD_BEEF);
        tick();
        chk_eq("t1_pulse", pad_if.biu_pad_retire, 1'b0);

        // Pending load blocks a younger ALU record until its late writeback.
        drive(1'b1, 32'h0000_0200, 1'b1, 1'b1, 5'd9, 32'h9999, 1'b0, 5'd0, 32'h0);
        tick();
        drive(1'b1, 32'h0000_0204, 1'b0, 1'b1, 5'd6, 32'h1, 1'b0, 5'd0, 32'h0);
        tick();
        idle();
        tick();
        tick();
        chk_eq("t2_blocked", pad_if.biu_pad_retire, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h55);
        tick();
        idle();
        tick();
        chk_eq("t2_pc0", pad_if.biu_pad_retire_pc, 32'h0000_0200);
        chk_eq("t2_idx0", pad_if.biu_pad_wb_gpr_index, 5'd7);
        chk_eq("t2_data0", pad_if.biu_pad_wb_gpr_data, 32'h55);
        tick();
        chk_eq("t2_pc1", pad_if.biu_pad_retire_pc, 32'h0000_0204);
        chk_eq("t2_ret1", pad_if.biu_pad_retire, 1'b1);

        // Write to x0: record emitted, write enable suppressed, data kept.
        drive(1'b1, 32'h0000_0300, 1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0);
        tick();
        idle();
        tick();
        chk_eq("t3_ret", pad_if.biu_pad_retire, 1'b1);
        chk_eq("t3_en", pad_if.biu_pad_wb_gpr_en, 1'b0);
        chk_eq("t3_data", pad_if.biu_pad_wb_gpr_data, 32'h1234);

        // Five retires behind a pending head: the fifth is dropped.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h0000_0400 + 32'(4 * i), (i == 0), 1'b1, 5'(10 + i),
                  32'(32'hA0 + i), 1'b0, 5'd0, 32'h0);
            tick();
        end
        chk_eq("t4_ovf", trace_ovf, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33);
        tick();
        idle();
        n_emit = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_emit += int'(pad_if.biu_pad_retire);
        end
        chk_eq("t4_emits", n_emit, 32'd4);

        // Reset with two pending entries, then a normal retire.
        drive(1'b1, 32'h0000_0500, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        drive(1'b1, 32'h0000_0504, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        idle();
        #2;
        rst_b = 1'b0;
        model_reset();
        #1;
        check_all();
        chk_eq("t6_busy", trace_busy, 1'b0);
        tick();
        rst_b = 1'b1;
        drive(1'b1, 32'h0000_0600, 1'b0, 1'b1, 5'd8, 32'h600, 1'b0, 5'd0, 32'h0);
        tick();
        idle();
        tick();
        chk_eq("t6_ret", pad_if.biu_pad_retire, 1'b1);
        chk_eq("t6_pc", pad_if.biu_pad_retire_pc, 32'h0000_0600);
        tick();

        // Late writeback into an empty buffer.
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44);
        tick();
        chk_eq("t5_err", trace_lwb_err, 1'b1);
        chk_eq("t5_ret", pad_if.biu_pad_retire, 1'b0);
        idle();
        tick();

        // Random traffic with one mid-run reset.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                #2;
                rst_b = 1'b0;
                model_reset();
                #1;
                check_all();
                tick();
                rst_b = 1'b1;
            end
            drive($urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 9) < 3,
                  $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom()), $urandom(),
                  $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom()), $urandom());
            tick();
        end
        idle();
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
